stream_rgb_unpacker: RTL and testbench



---
 rtl/stream_rgb_unpacker.sv | 271 +++++++++++++++++++++++++++
 tb/tb_stream_rgb_unpacker.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rgb_unpacker.sv
// stream_rgb_unpacker
//
// Unpacks a DMA word stream of packed RGB888 (4 pixels per 3 little-endian 32-bit words, one
// packet per frame) into a 24-bit pixel stream with start-of-frame, start-of-line and
// end-of-line markers. Packets that are malformed are dropped, and the block resynchronises on
// the next startofpacket. Each framing error raises a one-cycle err_pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   st_data/st_valid/st_startofpacket/st_endofpacket/st_ready
//                         packed word stream in (accept on st_valid && st_ready)
//   pix_data/pix_valid/pix_ready
//                         pixel stream out {R,G,B} (accept on pix_valid && pix_ready)
//   pix_sof/pix_sol/pix_eol
//                         frame/line markers, qualified by pix_valid
//   err_pulse             one-cycle pulse per framing error
//   err_cnt               saturating error count (only with STREAM_UNPACK_STATS_EN)
//
// Build option: define STREAM_UNPACK_STATS_EN to add the err_cnt output.

module stream_rgb_unpacker #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned CNT_W    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    input  logic        st_startofpacket,
    input  logic        st_endofpacket,
    output logic        st_ready,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_sol,
    output logic        pix_eol,
    output logic        err_pulse
`ifdef STREAM_UNPACK_STATS_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned WORDS  = H_ACTIVE * V_ACTIVE * 3 / 4;
    localparam int unsigned WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0]  X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  Y_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(WORDS - 1);

    typedef enum logic {
        StWaitSop,
        StActive
    } state_e;

    state_e              r_state, w_state_d;
    logic [1:0]          r_phase, w_phase_d;
    logic [23:0]         r_residue, w_residue_d;
    logic [CNT_W-1:0]    r_pix_x, w_pix_x_d;
    logic [CNT_W-1:0]    r_pix_y, w_pix_y_d;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_d;
    logic [23:0]         r_pix_data, w_pix_data_d;
    logic                r_pix_valid, w_pix_valid_d;
    logic                r_sof, w_sof_d;
    logic                r_sol, w_sol_d;
    logic                r_eol, w_eol_d;
    logic                r_err, w_err_d;
    logic                r_run;

    logic                w_out_free;
    logic                w_st_acc;
    logic                w_last_word;
    logic                w_load;
    logic                w_first;
    logic                w_drop;
    logic [23:0]         w_load_pix;
    logic [CNT_W-1:0]    w_x;
    logic [CNT_W-1:0]    w_y;

    assign w_out_free  = !r_pix_valid || pix_ready;
    assign w_last_word = (r_wcnt == W_LAST);

    // Drop mode accepts everything, but still waits for the output slot: an SOP word emits its
    // first pixel immediately, and the previous frame's last pixel may still be stalled there.
    // r_run keeps st_ready low while in reset and for the first cycle after release.
    assign st_ready = r_run && w_out_free && ((r_state == StWaitSop) || (r_phase != 2'd3));
    assign w_st_acc = st_valid && st_ready;

    always_comb begin
        w_state_d     = r_state;
        w_phase_d     = r_phase;
        w_residue_d   = r_residue;
        w_pix_x_d     = r_pix_x;
        w_pix_y_d     = r_pix_y;
        w_wcnt_d      = r_wcnt;
        w_pix_data_d  = r_pix_data;
        w_pix_valid_d = r_pix_valid && !pix_ready;
        w_sof_d       = r_sof;
        w_sol_d       = r_sol;
        w_eol_d       = r_eol;
        w_err_d       = 1'b0;
        w_load        = 1'b0;
        w_first       = 1'b0;
        w_drop        = 1'b0;
        w_load_pix    = '0;
        w_x           = r_pix_x;
        w_y           = r_pix_y;

        unique case (r_state)
            StWaitSop: begin
                if (w_st_acc && st_startofpacket) begin
                    // A one-word packet is always short: count it as an error and drop it.
                    if (st_endofpacket) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_first = 1'b1;
                    end
                end
            end
            StActive: begin
                if (r_phase == 2'd3) begin
                    // Fourth pixel comes entirely from the residue; no word is consumed.
                    if (w_out_free) begin
                        w_load      = 1'b1;
                        w_load_pix  = r_residue;
                        w_phase_d   = 2'd0;
                        w_residue_d = '0;
                    end
                end else if (w_st_acc) begin
                    if (st_startofpacket && (r_wcnt != '0)) begin
                        // New frame started before this one finished: restart on it.
                        w_err_d = 1'b1;
                        if (st_endofpacket) begin
                            w_drop = 1'b1;
                        end else begin
                            w_first = 1'b1;
                        end
                    end else if (st_endofpacket && !w_last_word) begin
                        w_err_d = 1'b1;
                        w_drop  = 1'b1;
                    end else begin
                        w_wcnt_d = r_wcnt + WCNT_W'(1);
                        if (w_last_word && !st_endofpacket) begin
                            w_err_d = 1'b1;
                        end
                        w_load = 1'b1;
                        case (r_phase)
                            2'd0: begin
                                w_load_pix  = st_data[23:0];
                                w_residue_d = {16'h0, st_data[31:24]};
                                w_phase_d   = 2'd1;
                            end
                            2'd1: begin
                                w_load_pix  = {st_data[15:0], r_residue[7:0]};
                                w_residue_d = {8'h0, st_data[31:16]};
                                w_phase_d   = 2'd2;
                            end
                            default: begin
                                w_load_pix  = {st_data[7:0], r_residue[15:0]};
                                w_residue_d = st_data[31:8];
                                w_phase_d   = 2'd3;
                            end
                        endcase
                    end
                end
            end
            default: begin
                w_drop = 1'b1;
            end
        endcase

        if (w_first) begin
            w_state_d   = StActive;
            w_load      = 1'b1;
            w_load_pix  = st_data[23:0];
            w_residue_d = {16'h0, st_data[31:24]};
            w_phase_d   = 2'd1;
            w_wcnt_d    = WCNT_W'(1);
            w_x         = '0;
            w_y         = '0;
        end

        if (w_drop) begin
            w_state_d   = StWaitSop;
            w_phase_d   = 2'd0;
            w_residue_d = '0;
            w_pix_x_d   = '0;
            w_pix_y_d   = '0;
            w_wcnt_d    = '0;
        end

        if (w_load) begin
            w_pix_data_d  = w_load_pix;
            w_pix_valid_d = 1'b1;
            w_sol_d       = (w_x == '0);
            w_eol_d       = (w_x == X_LAST);
            w_sof_d       = (w_x == '0) && (w_y == '0);
            if (w_x == X_LAST) begin
                w_pix_x_d = '0;
                if (w_y == Y_LAST) begin
                    // Last pixel of the frame is loaded: frame complete.
                    w_pix_y_d   = '0;
                    w_state_d   = StWaitSop;
                    w_phase_d   = 2'd0;
                    w_residue_d = '0;
                    w_wcnt_d    = '0;
                end else begin
                    w_pix_y_d = w_y + CNT_W'(1);
                end
            end else begin
                w_pix_x_d = w_x + CNT_W'(1);
                w_pix_y_d = w_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StWaitSop;
            r_phase     <= 2'd0;
            r_residue   <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_wcnt      <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_sol       <= 1'b0;
            r_eol       <= 1'b0;
            r_err       <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_phase     <= w_phase_d;
            r_residue   <= w_residue_d;
            r_pix_x     <= w_pix_x_d;
            r_pix_y     <= w_pix_y_d;
            r_wcnt      <= w_wcnt_d;
            r_pix_data  <= w_pix_data_d;
            r_pix_valid <= w_pix_valid_d;
            r_sof       <= w_sof_d;
            r_sol       <= w_sol_d;
            r_eol       <= w_eol_d;
            r_err       <= w_err_d;
            r_run       <= 1'b1;
        end
    end

    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign pix_sof   = r_sof;
    assign pix_sol   = r_sol;
    assign pix_eol   = r_eol;
    assign err_pulse = r_err;

`ifdef STREAM_UNPACK_STATS_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err_d && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_stream_rgb_unpacker.sv
// Bench for stream_rgb_unpacker (H_ACTIVE=8, V_ACTIVE=2, 12 words per frame). Words are driven
// through a randomised valid/ready handshake; a byte-stream reference model predicts every
// pixel, marker and error, and a negedge monitor compares the accepted pixels against it.

module tb_stream_rgb_unpacker;

    localparam int unsigned H     = 8;
    localparam int unsigned V     = 2;
    localparam int unsigned WORDS = H * V * 3 / 4;

    typedef struct packed {
        logic [23:0] d;
        logic        sof;
        logic        sol;
        logic        eol;
    } pix_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_startofpacket;
    logic        st_endofpacket;
    logic        st_ready;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_sol;
    logic        pix_eol;
    logic        err_pulse;
`ifdef STREAM_UNPACK_STATS_EN
    logic [15:0] err_cnt;
`endif

    stream_rgb_unpacker #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CNT_W    (12)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_startofpacket (st_startofpacket),
        .st_endofpacket   (st_endofpacket),
        .st_ready         (st_ready),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_sof          (pix_sof),
        .pix_sol          (pix_sol),
        .pix_eol          (pix_eol),
        .err_pulse        (err_pulse)
`ifdef STREAM_UNPACK_STATS_EN
        ,
        .err_cnt          (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    pix_t        exp_q[$];
    logic [23:0] got_log[$];
    logic [7:0]  m_bytes[$];
    bit          m_in_frame = 0;
    int          m_nwords   = 0;
    int          m_pix      = 0;
    int          m_err_exp  = 0;
    int          m_err_rst  = 0;
    int          err_seen   = 0;
    int          ready_mode = 0;
    bit          gaps       = 1;
    logic [31:0] pat_w[3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: frame = little-endian byte stream ----------------
    task automatic model_clear();
        m_in_frame = 0;
        m_nwords   = 0;
        m_pix      = 0;
        m_bytes.delete();
    endtask

    task automatic model_err();
        m_err_exp++;
        m_err_rst++;
    endtask

    task automatic model_word(input logic [31:0] d, input bit sop, input bit eop);
        pix_t p;
        int   x;
        if (sop && eop) begin
            model_err();
            model_clear();
            return;
        end
        if (sop) begin
            if (m_in_frame) model_err();
            model_clear();
            m_in_frame = 1;
        end else if (!m_in_frame) begin
            return;
        end else if (eop && (m_nwords + 1 != WORDS)) begin
            model_err();
            model_clear();
            return;
        end
        m_nwords++;
        for (int b = 0; b < 4; b++) m_bytes.push_back(d[8*b +: 8]);
        while (m_bytes.size() >= 3) begin
            p.d = {m_bytes[2], m_bytes[1], m_bytes[0]};
            void'(m_bytes.pop_front());
            void'(m_bytes.pop_front());
            void'(m_bytes.pop_front());
            x     = m_pix % H;
            p.sof = (m_pix == 0);
            p.sol = (x == 0);
            p.eol = (x == H - 1);
            exp_q.push_back(p);
            m_pix++;
        end
        if (m_nwords == WORDS) begin
            if (!eop) model_err();
            model_clear();
        end
    endtask

    // ---------------- clock, pix_ready driver, watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = !pix_ready;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- output monitor ----------------
    initial begin
        pix_t        e;
        bit          stalled;
        logic [23:0] held;
        stalled = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check_eq("stall_valid", pix_valid, 1);
                    check_eq("stall_data", pix_data, held);
                end
                if (err_pulse) err_seen++;
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("pix_expected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("pix_data", pix_data, e.d);
                        check_eq("pix_markers", {pix_sof, pix_sol, pix_eol},
                                 {e.sof, e.sol, e.eol});
                    end
                    got_log.push_back(pix_data);
                end
                stalled = pix_valid && !pix_ready;
                held    = pix_data;
                if (stalled) check_eq("stall_st_ready", st_ready, 0);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send_word(input logic [31:0] d, input bit sop, input bit eop,
                             output int waited);
        bit ok;
        waited           = 0;
        ok               = 0;
        st_data          = d;
        st_startofpacket = sop;
        st_endofpacket   = eop;
        st_valid         = 1'b1;
        while (!ok && waited <= 500) begin
            @(negedge clk);
            if (st_ready) ok = 1;
            else waited++;
        end
        if (ok) model_word(d, sop, eop);
        else check_eq("st_ready_timeout", st_ready, 1);
        @(posedge clk);
        #1;
        st_valid         = 1'b0;
        st_startofpacket = 1'b0;
        st_endofpacket   = 1'b0;
        st_data          = $urandom;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit pat, input int nwords, input int eop_at);
        int w;
        for (int i = 0; i < nwords; i++) begin
            send_word(pat ? pat_w[i % 3] : $urandom, (i == 0), (i == eop_at), w);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((exp_q.size() != 0) || pix_valid) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_done", ((exp_q.size() == 0) && !pix_valid) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        check_eq("err_total", err_seen, m_err_exp);
`ifdef STREAM_UNPACK_STATS_EN
        check_eq("err_cnt", err_cnt, m_err_rst);
`endif
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int err0;
        int w;
        int k;
        int kind;

        pat_w[0] = 32'h44332211;
        pat_w[1] = 32'h88776655;
        pat_w[2] = 32'hCCBBAA99;

        rst_n            = 1'b0;
        st_data          = '0;
        st_valid         = 1'b0;
        st_startofpacket = 1'b0;
        st_endofpacket   = 1'b0;
        #12;
        check_eq("rst_pix_valid", pix_valid, 0);
        check_eq("rst_pix_data", pix_data, 0);
        check_eq("rst_markers", {pix_sof, pix_sol, pix_eol}, 3'b000);
        check_eq("rst_err", err_pulse, 0);
        check_eq("rst_st_ready", st_ready, 0);
`ifdef STREAM_UNPACK_STATS_EN
        check_eq("rst_err_cnt", err_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Nominal frame, downstream always ready.
        ready_mode = 0;
        got_log.delete();
        send_frame(1, WORDS, WORDS - 1);
        drain();
        check_eq("t1_npix", got_log.size(), 16);
        check_eq("t1_p0", got_log[0], 24'h332211);
        check_eq("t1_p1", got_log[1], 24'h665544);
        check_eq("t1_p2", got_log[2], 24'h998877);
        check_eq("t1_p3", got_log[3], 24'hCCBBAA);
        check_eq("t1_p15", got_log[15], 24'hCCBBAA);

        // Same frame with pix_ready toggling.
        ready_mode = 1;
        got_log.delete();
        send_frame(1, WORDS, WORDS - 1);
        drain();
        check_eq("t2_npix", got_log.size(), 16);
        check_eq("t2_p5", got_log[5], 24'h665544);

        // EOP on word 5, then a good frame.
        ready_mode = 0;
        err0 = err_seen;
        send_frame(1, 5, 4);
        send_frame(1, WORDS, WORDS - 1);
        drain();
        check_eq("early_eop_err", err_seen - err0, 1);

        // Second SOP on word 7, then the new frame.
        err0 = err_seen;
        send_frame(1, 6, -1);
        send_frame(1, WORDS, WORDS - 1);
        drain();
        check_eq("mid_sop_err", err_seen - err0, 1);

        // Words without SOP are dropped silently, then a good frame.
        err0 = err_seen;
        for (int i = 0; i < 3; i++) begin
            send_word($urandom, 0, (i == 2), w);
            check_eq("drop_ready_wait", w, 0);
        end
        got_log.delete();
        send_frame(1, WORDS, WORDS - 1);
        drain();
        check_eq("drop_err", err_seen - err0, 0);
        check_eq("drop_npix", got_log.size(), 16);

        // Last word lacking EOP still completes the frame, with an error.
        err0 = err_seen;
        got_log.delete();
        send_frame(1, WORDS, -1);
        drain();
        check_eq("no_eop_err", err_seen - err0, 1);
        check_eq("no_eop_npix", got_log.size(), 16);

        // Reset mid-frame while a pixel is pending.
        gaps = 0;
        send_frame(1, 5, -1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pix_valid", pix_valid, 0);
        check_eq("midrst_st_ready", st_ready, 0);
        exp_q.delete();
        model_clear();
        m_err_rst = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gaps  = 1;
        repeat (3) @(posedge clk);
        #1;
        got_log.delete();
        send_frame(1, WORDS, WORDS - 1);
        drain();
        check_eq("post_rst_npix", got_log.size(), 16);

        // Randomised frames, errors and backpressure.
        for (int f = 0; f < 40; f++) begin
            ready_mode = $urandom_range(0, 2);
            kind       = $urandom_range(0, 9);
            if (kind < 5) begin
                send_frame(0, WORDS, WORDS - 1);
            end else if (kind == 5) begin
                k = $urandom_range(1, WORDS - 1);
                send_frame(0, k, k - 1);
            end else if (kind == 6) begin
                send_frame(0, WORDS, -1);
            end else if (kind == 7) begin
                k = $urandom_range(1, 3);
                for (int i = 0; i < k; i++) send_word($urandom, 0, 1'($urandom_range(0, 1)), w);
                send_frame(0, WORDS, WORDS - 1);
            end else begin
                send_frame(0, $urandom_range(1, WORDS - 1), -1);
                send_frame(0, WORDS, WORDS - 1);
            end
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
